// File: rtl/ps2_kbd_fifo_mmio_pkg.sv
// Shared encodings for the PS/2 keyboard receiver, event FIFO and
// memory-mapped register block.
package ps2_kbd_fifo_mmio_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam logic ADDR_DATA = 1'b0;
   localparam logic ADDR_STAT = 1'b1;

   localparam int ST_EMPTY  = 0;
   localparam int ST_OVF    = 1;
   localparam int ST_PERR   = 2;
   localparam int ST_IRQ_EN = 3;

   localparam int CTL_IRQ_EN = 0;
   localparam int CTL_FLUSH  = 1;
   localparam int CTL_CLR    = 2;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } kbd_evt_t;

   // Odd parity over the eight data bits plus the parity bit.
   function automatic logic odd_ok(
      input logic [7:0] d,
      input logic       p
   );
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_kbd_fifo_mmio_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, falling-edge detect,
// frame FSM and inter-edge timeout.
import ps2_kbd_fifo_mmio_pkg::*;

module ps2_frame_rx #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] ck_sync;
   logic [SYNC_STAGES-1:0] dt_sync;
   logic                   ck_prev;
   logic                   fall;
   logic                   dat;

   rx_state_t state, state_d;
   logic [7:0]   sh, sh_d;
   logic [2:0]   bc, bc_d;
   logic         par, par_d;
   logic [TW-1:0] tcnt, tcnt_d;
   logic         valid_d, err_d;

   // Idle-high reset values keep a spurious falling edge out after reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ck_sync <= '1;
         dt_sync <= '1;
         ck_prev <= 1'b1;
      end else begin
         ck_sync <= {ck_sync[SYNC_STAGES-2:0], ps2_clk_i};
         dt_sync <= {dt_sync[SYNC_STAGES-2:0], ps2_dat_i};
         ck_prev <= ck_sync[SYNC_STAGES-1];
      end
   end

   assign fall = ck_prev & ~ck_sync[SYNC_STAGES-1];
   assign dat  = dt_sync[SYNC_STAGES-1];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= RX_IDLE;
         sh         <= '0;
         bc         <= '0;
         par        <= 1'b0;
         tcnt       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_d;
         sh         <= sh_d;
         bc         <= bc_d;
         par        <= par_d;
         tcnt       <= tcnt_d;
         byte_valid <= valid_d;
         frame_err  <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      sh_d    = sh;
      bc_d    = bc;
      par_d   = par;
      tcnt_d  = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (state != RX_IDLE && !fall)
         tcnt_d = tcnt + TW'(1);
      if (fall) begin
         unique case (state)
            RX_IDLE: begin
               if (!dat) begin
                  state_d = RX_DATA;
                  bc_d    = '0;
               end
            end
            RX_DATA: begin
               sh_d = {dat, sh[7:1]};
               bc_d = bc + 3'd1;
               if (bc == 3'd7)
                  state_d = RX_PAR;
            end
            RX_PAR: begin
               par_d   = dat;
               state_d = RX_STOP;
            end
            RX_STOP: begin
               if (dat && odd_ok(sh, par))
                  valid_d = 1'b1;
               else
                  err_d = 1'b1;
               state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
         endcase
      end else if (state != RX_IDLE &&
                   tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d = RX_IDLE;
         err_d   = 1'b1;
      end
   end

   assign rx_byte = sh;

endmodule

// File: rtl/ps2_kbd_fifo_mmio.sv
// PS/2 keyboard event source: prefix decoder, event FIFO, CPU-visible
// DATA / STATUS / CTRL registers and level interrupt.
import ps2_kbd_fifo_mmio_pkg::*;

module ps2_kbd_fifo_mmio #(
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int DECODE_MODE    = 1,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ps2_clk_i,
   input  logic        ps2_dat_i,
   input  logic        bus_addr,
   input  logic        bus_re,
   input  logic        bus_we,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) u_rx (
      .CLK       (CLK),
      .RST       (RST),
      .ps2_clk_i (ps2_clk_i),
      .ps2_dat_i (ps2_dat_i),
      .rx_byte   (rx_byte),
      .byte_valid(rx_valid),
      .frame_err (rx_err)
   );

   kbd_evt_t        mem [FIFO_DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   cnt;
   logic            ext, brk;
   logic            perr, ovf, irq_en;

   logic            is_pre, push_req, push, pop;
   logic            rd_data, ctl_wr, flush, clr;
   logic            empty, full, ovf_set;
   kbd_evt_t        evt_in;
   logic [31:0]     status;
   logic            unused_wdata;

   always_comb begin
      is_pre   = (DECODE_MODE != 0) &&
                 (rx_byte == PS2_EXT || rx_byte == PS2_BRK);
      push_req = rx_valid && !is_pre;
      evt_in   = '{ext: ext, brk: brk, code: rx_byte};
      rd_data  = bus_re && bus_addr == ADDR_DATA;
      ctl_wr   = bus_we && bus_addr == ADDR_STAT;
      flush    = ctl_wr && bus_wdata[CTL_FLUSH];
      clr      = ctl_wr && bus_wdata[CTL_CLR];
      empty    = cnt == '0;
      full     = cnt == CW'(FIFO_DEPTH);
      pop      = rd_data && !empty;
      push     = push_req && (!full || pop);
      ovf_set  = push_req && full && !pop && !flush;
      status                = '0;
      status[15:8]          = 8'(cnt);
      status[ST_IRQ_EN]     = irq_en;
      status[ST_PERR]       = perr;
      status[ST_OVF]        = ovf;
      status[ST_EMPTY]      = empty;
   end

   assign unused_wdata = ^bus_wdata[31:3];

   // ext/brk only ever set in decode mode, so raw mode pushes zero flags.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (flush || rx_err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (rx_valid && DECODE_MODE != 0) begin
         if (rx_byte == PS2_EXT) begin
            ext <= 1'b1;
         end else if (rx_byte == PS2_BRK) begin
            brk <= 1'b1;
         end else begin
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push && !flush)
         mem[wptr] <= evt_in;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         perr      <= 1'b0;
         ovf       <= 1'b0;
         irq_en    <= 1'b0;
         irq       <= 1'b0;
         bus_rdata <= '0;
      end else begin
         perr <= rx_err | (perr & ~clr);
         ovf  <= ovf_set | (ovf & ~clr);
         irq  <= irq_en & ~empty;
         if (ctl_wr)
            irq_en <= bus_wdata[CTL_IRQ_EN];
         if (bus_re) begin
            if (bus_addr == ADDR_STAT)
               bus_rdata <= status;
            else if (empty)
               bus_rdata <= '0;
            else
               bus_rdata <= {1'b1, 21'b0, mem[rptr]};
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_fifo_mmio.sv
// Directed plus randomised bench for ps2_kbd_fifo_mmio against a
// queue-based event model.
module tb_ps2_kbd_fifo_mmio;

   localparam int DEPTH = 4;
   localparam int TOUT  = 200;
   localparam int H     = 20;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        ps2_clk_i = 1'b1;
   logic        ps2_dat_i = 1'b1;
   logic        bus_addr = 1'b0;
   logic        bus_re = 1'b0;
   logic        bus_we = 1'b0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        irq;

   int total = 0;
   int bad = 0;

   logic [9:0] q[$];
   logic       m_ext, m_brk, m_perr, m_ovf, m_irq_en;
   logic [31:0] obs;

   ps2_kbd_fifo_mmio #(
      .FIFO_DEPTH    (DEPTH),
      .TIMEOUT_CYCLES(TOUT),
      .DECODE_MODE   (1),
      .SYNC_STAGES   (2)
   ) u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .ps2_clk_i(ps2_clk_i),
      .ps2_dat_i(ps2_dat_i),
      .bus_addr (bus_addr),
      .bus_re   (bus_re),
      .bus_we   (bus_we),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata),
      .irq      (irq)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ext = 0; m_brk = 0; m_perr = 0; m_ovf = 0; m_irq_en = 0;
   endtask

   function automatic logic [31:0] exp_status();
      logic [7:0] c;
      c = 8'(q.size());
      return {16'h0, c, 4'h0, m_irq_en, m_perr, m_ovf, q.size() == 0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_dat_i = bits[i];
         repeat (H) @(posedge CLK);
         ps2_clk_i = 1'b0;
         repeat (H) @(posedge CLK);
         ps2_clk_i = 1'b1;
      end
   endtask

   task automatic send_raw(input logic [7:0] b, input logic badpar);
      logic p;
      p = ~(^b) ^ badpar;
      send_bits({1'b1, p, b, 1'b0}, 11);
      ps2_dat_i = 1'b1;
      repeat (20) @(posedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic badpar);
      send_raw(b, badpar);
      if (badpar) begin
         m_perr = 1; m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (q.size() == DEPTH) m_ovf = 1;
         else q.push_back({m_ext, m_brk, b});
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic bus_read(input logic a, output logic [31:0] d);
      @(negedge CLK);
      bus_re = 1'b1;
      bus_addr = a;
      @(negedge CLK);
      bus_re = 1'b0;
      d = bus_rdata;
   endtask

   task automatic rd_data(input string tag);
      logic [31:0] e;
      bus_read(1'b0, obs);
      e = (q.size() == 0) ? 32'h0 : {1'b1, 21'b0, q.pop_front()};
      chk(tag, obs, e);
   endtask

   task automatic rd_stat(input string tag);
      logic [31:0] e;
      e = exp_status();
      bus_read(1'b1, obs);
      chk(tag, obs, e);
   endtask

   task automatic ctrl_wr(input logic [2:0] w);
      @(negedge CLK);
      bus_we = 1'b1;
      bus_addr = 1'b1;
      bus_wdata = {29'h0, w};
      @(negedge CLK);
      bus_we = 1'b0;
      bus_wdata = '0;
      m_irq_en = w[0];
      if (w[1]) begin
         q.delete(); m_ext = 0; m_brk = 0;
      end
      if (w[2]) begin
         m_perr = 0; m_ovf = 0;
      end
   endtask

   task automatic chk_irq(input string tag);
      repeat (2) @(negedge CLK);
      chk(tag, {31'h0, irq}, {31'h0, m_irq_en && q.size() > 0});
   endtask

   initial begin
      int n;
      int op;
      logic [7:0] b;
      model_reset();
      repeat (3) @(negedge CLK);
      chk("rst_rdata", bus_rdata, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      rd_stat("rst_status");
      chk("rst_status_lit", obs, 32'h1);

      send_frame(8'h1C, 0);
      rd_stat("t1_status");
      chk("t1_status_lit", obs, 32'h0000_0100);
      rd_data("t1_data");
      chk("t1_data_lit", obs, 32'h8000_001C);
      rd_data("t1_empty");

      send_frame(8'hE0, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h75, 0);
      rd_stat("t2_status");
      rd_data("t2_data");
      chk("t2_data_lit", obs, 32'h8000_0375);

      for (int i = 0; i < 5; i++)
         send_frame(8'h11 + 8'(i), 0);
      rd_stat("t3_status");
      chk("t3_status_lit", obs, 32'h0000_0402);
      for (int i = 0; i < 4; i++)
         rd_data($sformatf("t3_data%0d", i));
      ctrl_wr(3'b100);
      rd_stat("t3_clr");

      send_frame(8'h2A, 1);
      send_bits(11'h7F0, 4);
      ps2_dat_i = 1'b1;
      repeat (TOUT + 100) @(posedge CLK);
      m_perr = 1; m_ext = 0; m_brk = 0;
      rd_stat("t4_status");
      chk("t4_status_lit", obs, 32'h0000_0005);
      send_frame(8'h1B, 0);
      rd_data("t4_data");
      ctrl_wr(3'b100);

      ctrl_wr(3'b001);
      chk_irq("t5_irq_empty");
      send_frame(8'h29, 0);
      chk_irq("t5_irq_set");
      rd_data("t5_data");
      chk("t5_irq_lag", {31'h0, irq}, 32'h1);
      @(negedge CLK);
      chk("t5_irq_clr", {31'h0, irq}, 32'h0);

      send_frame(8'h55, 0);
      send_frame(8'hE0, 0);
      send_bits(11'h7F0, 5);
      RST = 1'b0;
      ps2_clk_i = 1'b1;
      ps2_dat_i = 1'b1;
      repeat (3) @(negedge CLK);
      model_reset();
      RST = 1'b1;
      @(negedge CLK);
      chk("t6_rdata", bus_rdata, 32'h0);
      chk("t6_irq", {31'h0, irq}, 32'h0);
      rd_stat("t6_status");
      send_frame(8'h3C, 0);
      rd_data("t6_data");

      fork
         send_raw(8'h4D, 0);
         begin
            n = 0;
            while (u_dut.rx_valid !== 1'b1 && n < 3000) begin
               @(negedge CLK);
               n++;
            end
            chk("t6_valid_seen", {31'h0, n < 3000}, 32'h1);
            bus_we = 1'b1;
            bus_addr = 1'b1;
            bus_wdata = 32'h2;
            @(negedge CLK);
            bus_we = 1'b0;
            bus_wdata = '0;
         end
      join
      rd_stat("t6_flush_status");
      rd_data("t6_flush_data");

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 5);
         case (op)
            0, 1: begin
               b = 8'($urandom);
               if ($urandom_range(0, 3) == 0)
                  b = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
               send_frame(b, 0);
            end
            2: send_frame(8'($urandom), 1);
            3: rd_data($sformatf("rnd_data%0d", i));
            4: rd_stat($sformatf("rnd_stat%0d", i));
            default: ctrl_wr(3'($urandom));
         endcase
         chk_irq($sformatf("rnd_irq%0d", i));
      end
      rd_stat("end_status");
      for (int i = 0; i <= DEPTH; i++)
         rd_data($sformatf("end_data%0d", i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
